// File: rtl/uart_frame_pkg.sv
// Shared types and default geometry for the UART frame loader.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } frame_state_t;

  localparam int IMG_W_DEF   = 160;
  localparam int IMG_H_DEF   = 120;
  localparam int FRAME_BYTES = IMG_W_DEF * IMG_H_DEF;
  localparam int AW          = $clog2(FRAME_BYTES);

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Loadable idle down-counter: clear reloads, enable counts down, expired flags terminal count.
module uart_frame_timer #(
  parameter int LOAD = 1_000_000,
  localparam int CNT_W = (LOAD > 1) ? $clog2(LOAD) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= CNT_W'(LOAD - 1);
    end else if (clear) begin
      cnt <= CNT_W'(LOAD - 1);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Reaching zero after LOAD-1 decrements means LOAD clocks elapsed since the reload
  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/uart_frame_loader.sv
// Assembles UART bytes into a frame buffer and hands the frame to the detector.
// Optional trailing checksum byte enabled by defining UART_FRAME_CSUM_EN.
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int TIMEOUT_CYC = 1_000_000,
  localparam int FRAME_N    = IMG_W * IMG_H,
  localparam int ADDR_W     = $clog2(FRAME_N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_data_rdy,
  input  logic [7:0]        uart_data,
  output logic              fpga_can_receive,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              csum_err
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_N - 1);

  frame_state_t      state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [7:0]        wdata_nx;
  logic              tmo_nx;
  logic              ovr_nx;
  logic              timer_en;
  logic              timer_clr;
  logic              timer_exp;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]        sum, sum_nx;
  logic              cerr_nx;
`endif

  assign timer_en  = (state == RECV) || (state == CSUM);
  assign timer_clr = uart_data_rdy || !timer_en;

  uart_frame_timer #(
    .LOAD(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clr),
    .enable (timer_en),
    .expired(timer_exp)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    we_nx    = 1'b0;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    tmo_nx   = 1'b0;
    ovr_nx   = err_overrun;
`ifdef UART_FRAME_CSUM_EN
    sum_nx   = sum;
    cerr_nx  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (uart_data_rdy) begin
          we_nx    = 1'b1;
          addr_nx  = '0;
          wdata_nx = uart_data;
          cnt_nx   = ADDR_W'(1);
          state_nx = RECV;
`ifdef UART_FRAME_CSUM_EN
          sum_nx   = uart_data;
`endif
        end
      end
      RECV: begin
        // A fresh byte always beats a timeout landing on the same clock
        if (uart_data_rdy) begin
          we_nx    = 1'b1;
          addr_nx  = cnt;
          wdata_nx = uart_data;
`ifdef UART_FRAME_CSUM_EN
          sum_nx   = csum_add(sum, uart_data);
`endif
          if (cnt == LAST_PIX) begin
            cnt_nx = '0;
`ifdef UART_FRAME_CSUM_EN
            state_nx = CSUM;
`else
            state_nx = DONE;
`endif
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else if (timer_exp) begin
          tmo_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
`ifdef UART_FRAME_CSUM_EN
      CSUM: begin
        if (uart_data_rdy) begin
          if (uart_data == sum) begin
            state_nx = DONE;
          end else begin
            cerr_nx  = 1'b1;
            state_nx = IDLE;
          end
        end else if (timer_exp) begin
          tmo_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
`endif
      DONE: begin
        if (frame_ack) begin
          ovr_nx   = 1'b0;
          state_nx = IDLE;
        end else if (uart_data_rdy) begin
          ovr_nx = 1'b1;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      err_timeout      <= 1'b0;
      err_overrun      <= 1'b0;
      frame_valid      <= 1'b0;
      fpga_can_receive <= 1'b1;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      mem_we           <= we_nx;
      mem_addr         <= addr_nx;
      mem_wdata        <= wdata_nx;
      err_timeout      <= tmo_nx;
      err_overrun      <= ovr_nx;
      // Decoded from the next state so RTS drops on the very clock DONE is entered
      frame_valid      <= (state_nx == DONE);
      fpga_can_receive <= (state_nx != DONE);
    end
  end

`ifdef UART_FRAME_CSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum      <= '0;
      csum_err <= 1'b0;
    end else begin
      sum      <= sum_nx;
      csum_err <= cerr_nx;
    end
  end
`else
  assign csum_err = 1'b0;
`endif

endmodule
